// File: rtl/tt_sel_seq_pkg.sv
// -----------------------------------------------------------------------------
// tt_sel_seq_pkg
// Shared defaults and helpers for the tt_ctrl design-select sequencer.
//  - TT_SEL_* : default cycle counts for the select protocol phases
//  - max4 / tmr_width : size the single phase timer from the phase lengths
// -----------------------------------------------------------------------------
package tt_sel_seq_pkg;

  localparam int TT_SEL_RST_CYC = 4;
  localparam int TT_SEL_INC_HI  = 2;
  localparam int TT_SEL_INC_LO  = 2;
  localparam int TT_SEL_SETTLE  = 4;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width of a down-counter able to hold the longest phase length.
  function automatic int tmr_width(input int rst_cyc, input int inc_hi,
                                   input int inc_lo, input int settle);
    int w;
    w = $clog2(max4(rst_cyc, inc_hi, inc_lo, settle) + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/tt_sel_seq_timer.sv
// -----------------------------------------------------------------------------
// tt_sel_seq_timer
// Phase down-counter for the select sequencer.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  load       : reload the counter with value (on phase entry)
//  value      : reload value (phase length - 1)
//  done       : counter has reached zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module tt_sel_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// -----------------------------------------------------------------------------
// tt_sel_seq
// Sequencer for the tt_ctrl pad-level design-select protocol. A request
// names a target design address; the sequencer drops ena, walks the select
// counter (forward only if the target is ahead, otherwise reset then count
// from zero), waits for things to settle and re-enables.
// Ports:
//  clk, rst_n           : clock, asynchronous active-low reset
//  req_valid/req_ready  : request handshake (ready only in IDLE/ACTIVE)
//  req_addr             : target design address
//  req_off              : deselect only (counter reset, ena left low)
//  sel_rst_n, sel_inc   : to ctrl_sel_rst_n / ctrl_sel_inc
//  ena                  : to ctrl_ena
//  busy                 : a sequence is in progress
//  cur_addr, cur_valid  : address the tt_ctrl counter holds, and whether known
// -----------------------------------------------------------------------------
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int RST_CYC = TT_SEL_RST_CYC,
  parameter int INC_HI  = TT_SEL_INC_HI,
  parameter int INC_LO  = TT_SEL_INC_LO,
  parameter int SETTLE  = TT_SEL_SETTLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_off,
  output logic              sel_rst_n,
  output logic              sel_inc,
  output logic              ena,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DIS    = 3'd1;
  localparam logic [2:0] S_RST    = 3'd2;
  localparam logic [2:0] S_INC_HI = 3'd3;
  localparam logic [2:0] S_INC_LO = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_ACTIVE = 3'd6;

  localparam int TMR_W = tmr_width(RST_CYC, INC_HI, INC_LO, SETTLE);

  // Timer is loaded with length-1 so each phase lasts exactly its length.
  localparam logic [TMR_W-1:0] LD_RST    = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] LD_INC_HI = TMR_W'(INC_HI - 1);
  localparam logic [TMR_W-1:0] LD_INC_LO = TMR_W'(INC_LO - 1);
  localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE - 1);

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              off_q;
  logic [ADDR_W-1:0] delta;
  logic              accept;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_done;

  assign req_ready = (state == S_IDLE) || (state == S_ACTIVE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_ACTIVE: begin
        if (accept) nxt = S_DIS;
      end
      S_DIS: begin
        if (tmr_done) begin
          if (off_q)                                nxt = S_RST;
          else if (cur_valid && addr_q > cur_addr)  nxt = S_INC_HI;
          else if (cur_valid && addr_q == cur_addr) nxt = S_SETTLE;
          else                                      nxt = S_RST;
        end
      end
      S_RST: begin
        if (tmr_done) begin
          if (off_q)               nxt = S_IDLE;
          else if (addr_q == '0)   nxt = S_SETTLE;
          else                     nxt = S_INC_HI;
        end
      end
      S_INC_HI: begin
        if (tmr_done) nxt = S_INC_LO;
      end
      S_INC_LO: begin
        // delta was already decremented on INC_HI exit
        if (tmr_done) nxt = (delta == '0) ? S_SETTLE : S_INC_HI;
      end
      S_SETTLE: begin
        if (tmr_done) nxt = S_ACTIVE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Every transition changes state, so a state change is a phase entry.
  always_comb begin
    tmr_load  = (nxt != state);
    tmr_value = '0;
    case (nxt)
      S_DIS, S_SETTLE: tmr_value = LD_SETTLE;
      S_RST:           tmr_value = LD_RST;
      S_INC_HI:        tmr_value = LD_INC_HI;
      S_INC_LO:        tmr_value = LD_INC_LO;
      default:         tmr_value = '0;
    endcase
  end

  tt_sel_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel_rst_n <= 1'b0;
      sel_inc   <= 1'b0;
      ena       <= 1'b0;
      cur_addr  <= '0;
      cur_valid <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE, S_ACTIVE: begin
          if (accept) ena <= 1'b0;
        end
        S_DIS: begin
          if (nxt == S_RST) begin
            sel_rst_n <= 1'b0;
            cur_valid <= 1'b0;
          end else if (nxt == S_INC_HI) begin
            sel_inc <= 1'b1;
          end
        end
        S_RST: begin
          // Deselect-only leaves sel_rst_n low and cur_valid clear.
          if (tmr_done && !off_q) begin
            sel_rst_n <= 1'b1;
            cur_addr  <= '0;
            cur_valid <= 1'b1;
            sel_inc   <= (nxt == S_INC_HI);
          end
        end
        S_INC_HI: begin
          if (tmr_done) begin
            sel_inc  <= 1'b0;
            cur_addr <= cur_addr + ADDR_W'(1);
          end
        end
        S_INC_LO: begin
          if (nxt == S_INC_HI) sel_inc <= 1'b1;
        end
        S_SETTLE: begin
          if (tmr_done) ena <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request capture and remaining-increment count; only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr;
      off_q  <= req_off;
    end
    case (state)
      S_DIS:    if (nxt == S_INC_HI) delta <= addr_q - cur_addr;
      S_RST:    if (nxt == S_INC_HI) delta <= addr_q;
      S_INC_HI: if (tmr_done)        delta <= delta - ADDR_W'(1);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// -----------------------------------------------------------------------------
// tb_tt_sel_seq
// Directed bench for tt_sel_seq with RST_CYC=4, INC_HI=2, INC_LO=2, SETTLE=4.
// A negedge monitor keeps protocol invariants and edge counters; each test
// task drives a scenario and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_tt_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       req_off;
  logic       sel_rst_n;
  logic       sel_inc;
  logic       ena;
  logic       busy;
  logic [9:0] cur_addr;
  logic       cur_valid;

  int checks = 0;
  int errors = 0;

  int inc_rise = 0;
  int rst_low  = 0;
  int rst_fall = 0;
  int rst_rise = 0;
  int accepts  = 0;
  int hi_run   = 0;
  int lo_run   = 1000;
  logic prev_inc = 1'b0;
  logic prev_srn = 1'b0;

  tt_sel_seq #(
    .ADDR_W  (10),
    .RST_CYC (4),
    .INC_HI  (2),
    .INC_LO  (2),
    .SETTLE  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_off   (req_off),
    .sel_rst_n (sel_rst_n),
    .sel_inc   (sel_inc),
    .ena       (ena),
    .busy      (busy),
    .cur_addr  (cur_addr),
    .cur_valid (cur_valid)
  );

  always #5 clk = ~clk;

  // Protocol monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_inc = 1'b0;
      prev_srn = 1'b0;
      hi_run   = 0;
      lo_run   = 1000;
    end else begin
      checks++;
      if (sel_inc && (ena || !sel_rst_n)) begin
        errors++;
        $display("FAIL invariant: sel_inc=%0b ena=%0b sel_rst_n=%0b", sel_inc, ena, sel_rst_n);
      end
      checks++;
      if (req_ready !== !busy) begin
        errors++;
        $display("FAIL ready_vs_busy: req_ready=%0b busy=%0b", req_ready, busy);
      end
      if (req_valid && req_ready) accepts++;
      if (!sel_rst_n) rst_low++;
      if (prev_srn && !sel_rst_n) rst_fall++;
      if (!prev_srn && sel_rst_n) rst_rise++;
      if (sel_inc && !prev_inc) begin
        inc_rise++;
        if (lo_run < 8) begin
          checks++;
          if (lo_run != 2) begin
            errors++;
            $display("FAIL inc_lo_gap: got %0d cycles, want 2", lo_run);
          end
        end
        hi_run = 1;
      end else if (sel_inc) begin
        hi_run++;
      end else if (prev_inc) begin
        checks++;
        if (hi_run != 2) begin
          errors++;
          $display("FAIL inc_hi_width: got %0d cycles, want 2", hi_run);
        end
        lo_run = 1;
      end else if (lo_run < 1000) begin
        lo_run++;
      end
      prev_inc = sel_inc;
      prev_srn = sel_rst_n;
    end
  end

  // Present one request for a single accepted cycle.
  task automatic send(input logic [9:0] a, input logic off);
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: req_ready=%0b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_off   = off;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_off   = 1'b0;
  endtask

  // Cycles from the accept cycle until ena is seen high; -1 on timeout.
  task automatic wait_ena(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ena) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int inc0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_off   = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel_rst_n, sel_inc, ena, req_ready, busy, cur_valid} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_outputs: got srn/inc/ena/rdy/busy/cv=%b want 000100",
               {sel_rst_n, sel_inc, ena, req_ready, busy, cur_valid});
    end
    checks++;
    if (cur_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_cur_addr: got %0d want 0", cur_addr);
    end
    inc0 = inc_rise;
    repeat (100) @(negedge clk);
    checks++;
    if (inc_rise - inc0 != 0 || sel_rst_n !== 1'b0 || ena !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: inc pulses=%0d srn=%0b ena=%0b want 0/0/0",
               inc_rise - inc0, sel_rst_n, ena);
    end
  endtask

  task automatic run_seq(input string name, input logic [9:0] a, input int exp_lat,
                         input int exp_inc, input int exp_low, input int exp_fall);
    int inc0, low0, fall0, lat;
    send(a, 1'b0);
    inc0  = inc_rise;
    low0  = rst_low;
    fall0 = rst_fall;
    wait_ena(lat);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (inc_rise - inc0 != exp_inc) begin
      errors++;
      $display("FAIL %s_inc_pulses: got %0d want %0d", name, inc_rise - inc0, exp_inc);
    end
    checks++;
    if (rst_low - low0 != exp_low || rst_fall - fall0 != exp_fall) begin
      errors++;
      $display("FAIL %s_rst: low cycles %0d falls %0d want %0d/%0d",
               name, rst_low - low0, rst_fall - fall0, exp_low, exp_fall);
    end
    checks++;
    if (cur_addr !== a || cur_valid !== 1'b1 || sel_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL %s_final: cur_addr=%0d cv=%0b srn=%0b want %0d/1/1",
               name, cur_addr, cur_valid, sel_rst_n, a);
    end
  endtask

  task automatic test_from_reset();
    // DIS 4 + RST 4 + 3*(2+2) + SETTLE 4 + 1; sel_rst_n already low from reset
    run_seq("from_reset", 10'd3, 25, 3, 8, 0);
  endtask

  task automatic test_forward();
    run_seq("forward", 10'd5, 17, 2, 0, 0);
  endtask

  task automatic test_backward();
    run_seq("backward", 10'd2, 21, 2, 4, 1);
    run_seq("same", 10'd2, 9, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int acc0, lat, rdy_bad;
    @(posedge clk);
    #1;
    acc0      = accepts;
    rdy_bad   = 0;
    req_valid = 1'b1;
    req_addr  = 10'd4;
    req_off   = 1'b0;
    @(posedge clk);
    #1;
    req_addr = 10'd6;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ena) begin
        lat = i;
        break;
      end
      if (req_ready !== 1'b0) rdy_bad++;
    end
    checks++;
    if (lat != 17 || rdy_bad != 0) begin
      errors++;
      $display("FAIL b2b_first: latency %0d ready-while-busy %0d want 17/0", lat, rdy_bad);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_ena(lat);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d want 17", lat);
    end
    checks++;
    if (accepts - acc0 != 2 || cur_addr !== 10'd6) begin
      errors++;
      $display("FAIL b2b_accepts: accepts=%0d cur_addr=%0d want 2/6", accepts - acc0, cur_addr);
    end
  endtask

  task automatic test_mid_reset();
    int n, inc0, low0;
    logic seen;
    send(10'd9, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel_inc) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_reset_no_inc: sel_inc never rose, want a pulse");
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_rst_n, sel_inc, ena, busy, cur_valid} !== 5'b00000 || cur_addr !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: srn/inc/ena/busy/cv=%b cur_addr=%0d want 00000/0",
               {sel_rst_n, sel_inc, ena, busy, cur_valid}, cur_addr);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    // cur_valid was cleared, so even addr 1 goes through a counter reset.
    run_seq("after_reset", 10'd1, 17, 1, 8, 0);

    send(10'd7, 1'b1);
    inc0 = inc_rise;
    low0 = rst_low;
    wait_idle(n);
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL off_duration: busy for %0d want 9", n);
    end
    checks++;
    if ({sel_rst_n, ena, cur_valid, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL off_final: srn/ena/cv/rdy=%b want 0001",
               {sel_rst_n, ena, cur_valid, req_ready});
    end
    checks++;
    if (inc_rise - inc0 != 0 || rst_low - low0 != 4) begin
      errors++;
      $display("FAIL off_protocol: inc pulses %0d rst low %0d want 0/4",
               inc_rise - inc0, rst_low - low0);
    end
  endtask

  initial begin
    test_reset();
    test_from_reset();
    test_forward();
    test_backward();
    test_back_to_back();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
